// File: rtl/freq_meas_sequencer_if.sv
// Bus between the frequency-measurement sequencer and the digital measurement unit:
// probe mux select, start_stop/ack handshake and the two sample counts.
interface freq_meas_sequencer_if #(
    parameter int CH_W = 3
) ();
    logic [CH_W-1:0] ch_sel;
    logic            meas_start_stop;
    logic            meas_ack;
    logic            meas_ready;
    logic [31:0]     meas_period;
    logic [31:0]     meas_high;

    modport master (
        output ch_sel, meas_start_stop, meas_ack,
        input  meas_ready, meas_period, meas_high
    );

    modport slave (
        input  ch_sel, meas_start_stop, meas_ack,
        output meas_ready, meas_period, meas_high
    );
endinterface

// File: rtl/freq_meas_sequencer.sv
// Sequences one averaged period/high-time measurement: selects a probe channel, lets the mux
// settle, collects 2^k samples from the measurement unit and returns truncated averages.
//
// state  | meaning
// IDLE   | waiting for cmd_start, start_stop low
// SETTLE | mux switched, start_stop held low for SETTLE_CYC cycles
// RUN    | start_stop high, waiting for meas_ready or timeout
// ACK    | one-cycle meas_ack for the accepted sample
// DONE   | result_valid held until result_ack
module freq_meas_sequencer #(
    parameter int NUM_CH       = 8,
    parameter int CH_W         = 3,
    parameter int AVG_MAX_LOG2 = 4,
    parameter int SETTLE_CYC   = 16,
    parameter int TIMEOUT_CYC  = 2**24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_start,
    input  logic                 cmd_abort,
    input  logic [CH_W-1:0]      cfg_channel,
    input  logic [2:0]           cfg_avg_log2,
    freq_meas_sequencer_if.master mu,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ack,
    output logic [31:0]          period_avg,
    output logic [31:0]          high_avg,
    output logic                 timeout_err
);

    localparam int SUM_W   = 32 + AVG_MAX_LOG2;
    localparam int CNT_W   = AVG_MAX_LOG2 + 1;
    localparam int TMR_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(NUM_CH - 1);
    localparam logic [2:0]       K_MAX        = 3'(AVG_MAX_LOG2);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_ACK    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]       state, next_state;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] sample_target;
    logic [2:0]       k_q;
    logic [SUM_W-1:0] period_sum, high_sum;
    logic [SUM_W-1:0] period_shift, high_shift;
    logic [CH_W-1:0]  ch_sel_q;
    logic [CH_W-1:0]  ch_clamped;
    logic [2:0]       k_clamped;
    logic             start_stop_q, ack_q;

    assign mu.ch_sel          = ch_sel_q;
    assign mu.meas_start_stop = start_stop_q;
    assign mu.meas_ack        = ack_q;

    assign ch_clamped    = (int'(cfg_channel) >= NUM_CH) ? CH_LAST : cfg_channel;
    assign k_clamped     = (cfg_avg_log2 > K_MAX) ? K_MAX : cfg_avg_log2;
    assign sample_target = CNT_W'(1) << k_q;
    assign period_shift  = period_sum >> k_q;
    assign high_shift    = high_sum >> k_q;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (cmd_start && !cmd_abort) next_state = ST_SETTLE;
            ST_SETTLE: if (timer == SETTLE_LAST) next_state = ST_RUN;
            // a sample arriving on the timeout cycle is still taken
            ST_RUN: begin
                if (mu.meas_ready)              next_state = ST_ACK;
                else if (timer == TIMEOUT_LAST) next_state = ST_DONE;
            end
            ST_ACK:    next_state = (sample_cnt == sample_target) ? ST_DONE : ST_RUN;
            ST_DONE:   if (result_ack) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
        if (cmd_abort && state != ST_IDLE) next_state = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            timer        <= '0;
            sample_cnt   <= '0;
            k_q          <= '0;
            period_sum   <= '0;
            high_sum     <= '0;
            ch_sel_q     <= '0;
            start_stop_q <= 1'b0;
            ack_q        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            period_avg   <= '0;
            high_avg     <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= next_state;
            start_stop_q <= (next_state == ST_RUN) || (next_state == ST_ACK);
            ack_q        <= (next_state == ST_ACK);
            busy         <= (next_state == ST_SETTLE) || (next_state == ST_RUN) ||
                            (next_state == ST_ACK);
            result_valid <= (next_state == ST_DONE);

            case (state)
                ST_IDLE: begin
                    if (next_state == ST_SETTLE) begin
                        ch_sel_q    <= ch_clamped;
                        k_q         <= k_clamped;
                        period_sum  <= '0;
                        high_sum    <= '0;
                        sample_cnt  <= '0;
                        timer       <= '0;
                        timeout_err <= 1'b0;
                        period_avg  <= '0;
                        high_avg    <= '0;
                    end
                end
                ST_SETTLE: begin
                    timer <= (next_state == ST_RUN) ? '0 : timer + TMR_W'(1);
                end
                ST_RUN: begin
                    timer <= timer + TMR_W'(1);
                    if (next_state == ST_ACK) begin
                        period_sum <= period_sum + SUM_W'(mu.meas_period);
                        high_sum   <= high_sum + SUM_W'(mu.meas_high);
                        sample_cnt <= sample_cnt + CNT_W'(1);
                    end else if (next_state == ST_DONE) begin
                        timeout_err <= 1'b1;
                        period_avg  <= '0;
                        high_avg    <= '0;
                    end
                end
                ST_ACK: begin
                    timer <= '0;
                    if (next_state == ST_DONE) begin
                        period_avg <= period_shift[31:0];
                        high_avg   <= high_shift[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Directed bench for freq_meas_sequencer with a behavioural measurement unit and a result scoreboard.
module tb_freq_meas_sequencer;
    localparam int NUM_CH       = 6;
    localparam int CH_W         = 3;
    localparam int AVG_MAX_LOG2 = 4;
    localparam int SETTLE_CYC   = 16;
    localparam int TIMEOUT_CYC  = 1000;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            cmd_start = 1'b0;
    logic            cmd_abort = 1'b0;
    logic            result_ack = 1'b0;
    logic [CH_W-1:0] cfg_channel = '0;
    logic [2:0]      cfg_avg_log2 = '0;
    logic            busy, result_valid, timeout_err;
    logic [31:0]     period_avg, high_avg;

    freq_meas_sequencer_if #(.CH_W(CH_W)) mu ();

    freq_meas_sequencer #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .AVG_MAX_LOG2(AVG_MAX_LOG2),
        .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cfg_channel(cfg_channel), .cfg_avg_log2(cfg_avg_log2), .mu(mu),
        .busy(busy), .result_valid(result_valid), .result_ack(result_ack),
        .period_avg(period_avg), .high_avg(high_avg), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p;
        logic [31:0] h;
        logic        to;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] smp_p[$];
    logic [31:0] smp_h[$];

    int checks = 0;
    int errors = 0;
    int ack_count = 0;
    int settle_cnt = 0;
    int cyc = 0;
    int run_cyc = 0;
    int valid_cyc = 0;
    bit unit_en = 1'b1;

    // Measurement unit model: raises ready a few cycles into RUN, drops it on ack or start_stop low.
    initial begin
        int  dly;
        bit  prev_ss, prev_rv;
        dly = 0; prev_ss = 0; prev_rv = 0;
        mu.meas_ready  = 1'b0;
        mu.meas_period = '0;
        mu.meas_high   = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n || !mu.meas_start_stop) begin
                mu.meas_ready = 1'b0;
                dly = 0;
            end else if (mu.meas_ready) begin
                if (mu.meas_ack) mu.meas_ready = 1'b0;
            end else if (unit_en && smp_p.size() > 0) begin
                dly++;
                if (dly >= 3) begin
                    mu.meas_ready  = 1'b1;
                    mu.meas_period = smp_p.pop_front();
                    mu.meas_high   = smp_h.pop_front();
                    dly = 0;
                end
            end
            if (mu.meas_ack) ack_count++;
            if (busy && !mu.meas_start_stop) settle_cnt++;
            if (mu.meas_start_stop && !prev_ss) run_cyc = cyc;
            if (result_valid && !prev_rv) valid_cyc = cyc;
            prev_ss = mu.meas_start_stop;
            prev_rv = result_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic add_sample(input int p, input int h);
        smp_p.push_back(32'(p));
        smp_h.push_back(32'(h));
    endtask

    task automatic start_run(input int ch, input int k);
        @(negedge clk);
        settle_cnt   = 0;
        ack_count    = 0;
        cfg_channel  = CH_W'(ch);
        cfg_avg_log2 = 3'(k);
        cmd_start    = 1'b1;
        @(negedge clk);
        cmd_start    = 1'b0;
    endtask

    task automatic wait_result(input string tag, input bit also_start);
        bit   got;
        exp_t e;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (result_valid) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, 32'(got), 32'd1);
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_period"}, period_avg, e.p);
            check({tag, "_high"}, high_avg, e.h);
            check({tag, "_timeout"}, 32'(timeout_err), 32'(e.to));
            check({tag, "_busy_done"}, 32'(busy), 32'd0);
            repeat (3) @(negedge clk);
            check({tag, "_held"}, 32'(result_valid), 32'd1);
            result_ack = 1'b1;
            if (also_start) cmd_start = 1'b1;
            @(negedge clk);
            result_ack = 1'b0;
            cmd_start  = 1'b0;
            check({tag, "_valid_clr"}, 32'(result_valid), 32'd0);
        end
    endtask

    initial begin
        int  p_sum, h_sum;
        bit  seen;

        repeat (3) @(negedge clk);
        check("rst_start_stop", 32'(mu.meas_start_stop), 32'd0);
        check("rst_ack", 32'(mu.meas_ack), 32'd0);
        check("rst_ch_sel", 32'(mu.ch_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_period", period_avg, 32'd0);
        check("rst_high", high_avg, 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // channel 2, four identical samples; a start while busy is ignored
        repeat (4) add_sample(100, 30);
        sb.push_back('{p: 32'd100, h: 32'd30, to: 1'b0});
        start_run(2, 2);
        check("basic_ch_sel", 32'(mu.ch_sel), 32'd2);
        check("basic_busy", 32'(busy), 32'd1);
        repeat (5) @(negedge clk);
        cfg_channel = CH_W'(4);
        cmd_start   = 1'b1;
        @(negedge clk);
        cmd_start   = 1'b0;
        check("busy_start_ignored", 32'(mu.ch_sel), 32'd2);
        wait_result("basic", 1'b0);
        check("basic_settle_len", 32'(settle_cnt), 32'(SETTLE_CYC));
        check("basic_acks", 32'(ack_count), 32'd4);

        // truncating average; start together with result_ack must not launch a run
        add_sample(99, 40);
        add_sample(100, 41);
        sb.push_back('{p: 32'd99, h: 32'd40, to: 1'b0});
        start_run(1, 1);
        wait_result("trunc", 1'b1);
        check("done_start_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check("done_start_idle", 32'(busy), 32'd0);
        check("done_start_novalid", 32'(result_valid), 32'd0);

        // unit never answers: timeout exactly TIMEOUT_CYC after RUN entry
        unit_en = 1'b0;
        sb.push_back('{p: 32'd0, h: 32'd0, to: 1'b1});
        start_run(0, 0);
        wait_result("tmo", 1'b0);
        check("tmo_acks", 32'(ack_count), 32'd0);
        check("tmo_latency", 32'(valid_cyc - run_cyc), 32'(TIMEOUT_CYC));
        unit_en = 1'b1;

        // abort after the second ack of a k=3 run, then a clean run
        repeat (8) add_sample(200, 50);
        start_run(3, 3);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ack_count >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_two_acks", 32'(seen), 32'd1);
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        check("abort_start_stop", 32'(mu.meas_start_stop), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(result_valid), 32'd0);
        repeat (30) @(negedge clk);
        check("abort_no_result", 32'(result_valid), 32'd0);
        check("abort_ack_total", 32'(ack_count), 32'd2);
        smp_p.delete();
        smp_h.delete();
        add_sample(55, 22);
        sb.push_back('{p: 32'd55, h: 32'd22, to: 1'b0});
        start_run(1, 0);
        wait_result("post_abort", 1'b0);

        // out-of-range channel and k clamp to 5 and 4 (16 samples)
        p_sum = 0;
        h_sum = 0;
        for (int i = 0; i < 16; i++) begin
            add_sample(1000 + i, 500 + i);
            p_sum += 1000 + i;
            h_sum += 500 + i;
        end
        sb.push_back('{p: 32'(p_sum >> 4), h: 32'(h_sum >> 4), to: 1'b0});
        start_run(7, 7);
        check("clamp_ch_sel", 32'(mu.ch_sel), 32'd5);
        wait_result("clamp", 1'b0);
        check("clamp_acks", 32'(ack_count), 32'd16);

        // asynchronous reset in the middle of RUN
        smp_p.delete();
        smp_h.delete();
        start_run(4, 2);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mu.meas_start_stop) begin
                seen = 1'b1;
                break;
            end
        end
        check("rstrun_in_run", 32'(seen), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rstrun_start_stop", 32'(mu.meas_start_stop), 32'd0);
        check("rstrun_busy", 32'(busy), 32'd0);
        check("rstrun_ch_sel", 32'(mu.ch_sel), 32'd0);
        check("rstrun_valid", 32'(result_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstrun_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
